dff_share_arbiter: RTL and testbench

- Round-robin arbiter that shares one DATA_W-bit D-flip-flop register between NUM_REQ requesters.
- Each cycle it picks at most one requester and loads that requester's data into the shared register. It records who owns the value and then holds the register stable for HOLD_CYC cycles before accepting the next write.
- Sits in front of the DFF datapath as its write sequencer.

---
 rtl/dff_share_arbiter.sv | 177 +++++++++++++++++
 tb/tb_dff_share_arbiter.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/dff_share_arbiter.sv
// -----------------------------------------------------------------------------
// dff_share_arbiter
//
// Round-robin write sequencer for one shared DATA_W-bit register. Each cycle
// at most one requester is chosen and its data is loaded into the shared
// register. The arbiter records which requester owns the value, then holds
// the register stable for HOLD_CYC cycles before it accepts another write.
//
// Optional feature (macro DFF_SHARE_ARB_LOCK_EN): adds the per-requester
// "lock" input. A requester that currently owns a valid value and asserts
// both req and lock wins again regardless of the round-robin pointer. A
// locked capture does not advance the pointer.
//
// Ports:
//   clk     in   rising-edge clock
//   rst_n   in   synchronous active-low reset, priority over all inputs
//   req     in   [NUM_REQ]         level write request per requester
//   wdata   in   [NUM_REQ*DATA_W]  requester i drives [i*DATA_W +: DATA_W]
//   lock    in   [NUM_REQ]         (DFF_SHARE_ARB_LOCK_EN only) keep ownership
//   clr     in   synchronous flush of q_valid and arbitration state
//   grant   out  [NUM_REQ]  one-hot single-cycle pulse on capture
//   q       out  [DATA_W]   shared register value
//   q_valid out  q holds captured data
//   owner   out  [IDX_W]    index of requester whose data is in q
//   busy    out  high while holding; requests are ignored
// -----------------------------------------------------------------------------
module dff_share_arbiter #(
    parameter int NUM_REQ  = 4,
    parameter int DATA_W   = 8,
    parameter int HOLD_CYC = 2,
    parameter int IDX_W    = $clog2(NUM_REQ)
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [NUM_REQ-1:0]          req,
    input  logic [NUM_REQ*DATA_W-1:0]   wdata,
`ifdef DFF_SHARE_ARB_LOCK_EN
    input  logic [NUM_REQ-1:0]          lock,
`endif
    input  logic                        clr,
    output logic [NUM_REQ-1:0]          grant,
    output logic [DATA_W-1:0]           q,
    output logic                        q_valid,
    output logic [IDX_W-1:0]            owner,
    output logic                        busy
);

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    // Counter value loaded on capture; the HOLD state lasts HOLD_CYC edges.
    localparam logic [7:0] HOLD_RELOAD = (HOLD_CYC > 0) ? 8'(HOLD_CYC - 1) : 8'd0;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REQ - 1);

    state_t              state_q, state_d;
    logic [IDX_W-1:0]    ptr_q, ptr_d;
    logic [7:0]          cnt_q, cnt_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic                valid_q, valid_d;
    logic [IDX_W-1:0]    owner_q, owner_d;
    logic [NUM_REQ-1:0]  grant_q, grant_d;

    // Per-requester data slices.
    logic [DATA_W-1:0]   wdata_arr [NUM_REQ];

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_slice
            assign wdata_arr[gi] = wdata[gi*DATA_W +: DATA_W];
        end
    endgenerate

    // Round-robin search starting at ptr_q, wrapping at NUM_REQ.
    logic             rr_found;
    logic [IDX_W-1:0] rr_win;

    always_comb begin
        int idx;
        rr_found = 1'b0;
        rr_win   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = int'(ptr_q) + k;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            if (!rr_found && req[IDX_W'(idx)]) begin
                rr_found = 1'b1;
                rr_win   = IDX_W'(idx);
            end
        end
    end

    // A locked owner only counts while it still owns valid data.
    logic locked;
`ifdef DFF_SHARE_ARB_LOCK_EN
    assign locked = valid_q && req[owner_q] && lock[owner_q];
`else
    assign locked = 1'b0;
`endif

    logic             cap;
    logic [IDX_W-1:0] win;
    assign cap = locked || rr_found;
    assign win = locked ? owner_q : rr_win;

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        valid_d = valid_q;
        owner_d = owner_q;
        grant_d = '0;

        if (clr) begin
            // Flush: data and owner are kept, only validity and FSM clear.
            valid_d = 1'b0;
            state_d = IDLE;
            cnt_d   = 8'd0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (cap) begin
                        data_d  = wdata_arr[win];
                        owner_d = win;
                        valid_d = 1'b1;
                        grant_d = NUM_REQ'(1) << win;
                        if (!locked) begin
                            ptr_d = (win == LAST_IDX) ? '0 : win + 1'b1;
                        end
                        if (HOLD_CYC > 0) begin
                            state_d = HOLD;
                            cnt_d   = HOLD_RELOAD;
                        end
                    end
                end
                HOLD: begin
                    if (cnt_q == 8'd0) begin
                        state_d = IDLE;
                    end else begin
                        cnt_d = cnt_q - 8'd1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            cnt_q   <= 8'd0;
            data_q  <= '0;
            valid_q <= 1'b0;
            owner_q <= '0;
            grant_q <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            owner_q <= owner_d;
            grant_q <= grant_d;
        end
    end

    assign grant   = grant_q;
    assign q       = data_q;
    assign q_valid = valid_q;
    assign owner   = owner_q;
    assign busy    = (state_q == HOLD);

endmodule

// File: tb/tb_dff_share_arbiter.sv
// -----------------------------------------------------------------------------
// Bench for dff_share_arbiter: two instances (HOLD_CYC=2 and HOLD_CYC=0) share
// the same stimulus. A behavioural model counts remaining hold edges and
// searches requesters in rotation order with plain integer arithmetic.
// -----------------------------------------------------------------------------
module tb_dff_share_arbiter;

    localparam int NR = 4;
    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [NR-1:0] req;
    logic [NR*DW-1:0] wdata;
    logic          clr;
`ifdef DFF_SHARE_ARB_LOCK_EN
    logic [NR-1:0] lock;
`endif

    logic [NR-1:0] grant_a, grant_b;
    logic [DW-1:0] q_a, q_b;
    logic          qv_a, qv_b;
    logic [1:0]    own_a, own_b;
    logic          busy_a, busy_b;

    int compared   = 0;
    int mismatched = 0;

    always #5 clk = ~clk;

    dff_share_arbiter #(.NUM_REQ(NR), .DATA_W(DW), .HOLD_CYC(2)) dut_a (
        .clk(clk), .rst_n(rst_n), .req(req), .wdata(wdata),
`ifdef DFF_SHARE_ARB_LOCK_EN
        .lock(lock),
`endif
        .clr(clr), .grant(grant_a), .q(q_a), .q_valid(qv_a),
        .owner(own_a), .busy(busy_a));

    dff_share_arbiter #(.NUM_REQ(NR), .DATA_W(DW), .HOLD_CYC(0)) dut_b (
        .clk(clk), .rst_n(rst_n), .req(req), .wdata(wdata),
`ifdef DFF_SHARE_ARB_LOCK_EN
        .lock(lock),
`endif
        .clr(clr), .grant(grant_b), .q(q_b), .q_valid(qv_b),
        .owner(own_b), .busy(busy_b));

    // Reference model state per instance (0 -> HOLD_CYC=2, 1 -> HOLD_CYC=0).
    int hc      [2] = '{2, 0};
    int m_ptr   [2];
    int m_hold  [2];   // edges still to be ignored
    int m_q     [2];
    int m_valid [2];
    int m_owner [2];
    int m_grant [2];

    task automatic model_edge();
        int w;
        bit lk;
        for (int d = 0; d < 2; d++) begin
            m_grant[d] = 0;
            if (!rst_n) begin
                m_q[d] = 0; m_valid[d] = 0; m_owner[d] = 0;
                m_ptr[d] = 0; m_hold[d] = 0;
            end else if (clr) begin
                m_valid[d] = 0;
                m_hold[d]  = 0;
            end else if (m_hold[d] > 0) begin
                m_hold[d] = m_hold[d] - 1;
            end else if (req != '0) begin
                w  = -1;
                lk = 1'b0;
`ifdef DFF_SHARE_ARB_LOCK_EN
                if (m_valid[d] != 0 && req[m_owner[d]] && lock[m_owner[d]]) begin
                    w  = m_owner[d];
                    lk = 1'b1;
                end
`endif
                for (int k = 0; k < NR && w < 0; k++) begin
                    if (req[(m_ptr[d] + k) % NR]) w = (m_ptr[d] + k) % NR;
                end
                m_q[d]     = int'(wdata[w*DW +: DW]);
                m_owner[d] = w;
                m_valid[d] = 1;
                m_grant[d] = 1 << w;
                if (!lk) m_ptr[d] = (w + 1) % NR;
                m_hold[d]  = hc[d];
            end
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string step);
        chk({step, " a.grant"}, 32'(grant_a), 32'(m_grant[0]));
        chk({step, " a.q"},     32'(q_a),     32'(m_q[0]));
        chk({step, " a.qv"},    32'(qv_a),    32'(m_valid[0]));
        chk({step, " a.owner"}, 32'(own_a),   32'(m_owner[0]));
        chk({step, " a.busy"},  32'(busy_a),  32'(m_hold[0] > 0));
        chk({step, " b.grant"}, 32'(grant_b), 32'(m_grant[1]));
        chk({step, " b.q"},     32'(q_b),     32'(m_q[1]));
        chk({step, " b.qv"},    32'(qv_b),    32'(m_valid[1]));
        chk({step, " b.owner"}, 32'(own_b),   32'(m_owner[1]));
        chk({step, " b.busy"},  32'(busy_b),  32'(m_hold[1] > 0));
        $display("%s rst_n=%b clr=%b req=%b | a: g=%b q=%h v=%b o=%0d b=%b | b: g=%b q=%h v=%b o=%0d b=%b",
                 step, rst_n, clr, req, grant_a, q_a, qv_a, own_a, busy_a,
                 grant_b, q_b, qv_b, own_b, busy_b);
    endtask

    // One clock edge: model advances on the inputs sampled at the edge,
    // outputs are checked 1 time unit later.
    task automatic step(input string name);
        @(posedge clk);
        model_edge();
        #1;
        check_all(name);
    endtask

    initial begin
        for (int d = 0; d < 2; d++) begin
            m_ptr[d] = 0; m_hold[d] = 0; m_q[d] = 0;
            m_valid[d] = 0; m_owner[d] = 0; m_grant[d] = 0;
        end
        rst_n = 1'b0;
        clr   = 1'b0;
        req   = 4'b1111;
        wdata = {8'h44, 8'h33, 8'h22, 8'h11};
`ifdef DFF_SHARE_ARB_LOCK_EN
        lock  = '0;
`endif

        // Reset held for three edges with all requests pending.
        repeat (3) step("reset");
        // Direct reset-value checks independent of the model.
        chk("reset q_a", 32'(q_a), 32'h0);
        chk("reset grant_a", 32'(grant_a), 32'h0);

        // Round-robin rotation under continuous requests.
        rst_n = 1'b1;
        repeat (14) step("rr");

        // Single persistent requester.
        req   = 4'b0100;
        wdata = {8'h00, 8'hA5, 8'h00, 8'h00};
        repeat (6) step("single");
        chk("single b.q", 32'(q_b), 32'hA5);
        chk("single b.owner", 32'(own_b), 32'd2);

        // Clear wins over a simultaneous request.
        req   = 4'b0010;
        wdata = {8'h01, 8'h02, 8'h5C, 8'h04};
        clr   = 1'b1;
        step("clr");
        chk("clr b.qv", 32'(qv_b), 32'd0);
        clr   = 1'b0;
        step("clr_rel");
        chk("clr_rel b.grant", 32'(grant_b), 32'b0010);

        // Reset while holding.
        req   = 4'b1111;
        step("pre_rst");
        rst_n = 1'b0;
        step("mid_rst");
        rst_n = 1'b1;
        req   = 4'b1001;
        wdata = {8'h99, 8'h00, 8'h00, 8'h66};
        step("post_rst");
        chk("post_rst a.grant", 32'(grant_a), 32'b0001);
        repeat (3) step("post_rst");

        // Idle with no requests.
        req = '0;
        repeat (3) step("idle");

`ifdef DFF_SHARE_ARB_LOCK_EN
        // Requester 1 locks ownership, then drops the lock.
        req   = 4'b0010;
        wdata = {8'hD4, 8'hC3, 8'hB2, 8'hA1};
        repeat (3) step("lock_take");
        req  = 4'b1111;
        lock = 4'b0010;
        repeat (9) step("lock_hold");
        lock = 4'b0000;
        repeat (6) step("lock_drop");
`endif

        // Randomized traffic.
        for (int i = 0; i < 300; i++) begin
            req   = 4'($urandom_range(0, 15));
            wdata = $urandom;
            clr   = ($urandom_range(0, 15) == 0);
            rst_n = ($urandom_range(0, 63) != 0);
`ifdef DFF_SHARE_ARB_LOCK_EN
            lock  = 4'($urandom_range(0, 15));
`endif
            step("rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
